// File: rtl/led_det_pkg.sv
// Shared types and constants for the LED pattern mode detector.
package led_det_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      LOCKED
   } state_t;

   localparam logic [1:0] MODE_ROTL  = 2'd0;
   localparam logic [1:0] MODE_ROTR  = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_FIXED = 2'd3;

   localparam logic [7:0] FIXED_PATTERN = 8'hAA;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b0, v[0]} + {2'b0, v[1]}
           + {2'b0, v[2]} + {2'b0, v[3]};
   endfunction

   // Priority pick; callers only pass one-hot vectors.
   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = MODE_ROTL;
      case (1'b1)
         v[0]: idx = MODE_ROTL;
         v[1]: idx = MODE_ROTR;
         v[2]: idx = MODE_BLINK;
         v[3]: idx = MODE_FIXED;
         default: idx = MODE_ROTL;
      endcase
      return idx;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/led_step_match.sv
// Combinational step classifier: which generator modes could turn
// prev into cur in one step.
module led_step_match
   import led_det_pkg::*;
(
   input  logic [7:0] prev,
   input  logic [7:0] cur,
   output logic [3:0] m
);

   assign m[0] = (cur == {prev[6:0], prev[7]});
   assign m[1] = (cur == {prev[0], prev[7:1]});
   assign m[2] = (cur == ~prev);
   assign m[3] = (cur == FIXED_PATTERN);

endmodule

// File: rtl/led_mode_detector.sv
// Infers the running LED generator mode from consecutive samples.
// Define LED_DET_ERRCNT_EN to add the saturating err_cnt output.
module led_mode_detector
   import led_det_pkg::*;
#(
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 2
`ifdef LED_DET_ERRCNT_EN
   ,
   parameter int ERR_W    = 8
`endif
)(
   input  logic             clk_1,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [7:0]       led_in,
   output logic [1:0]       mode_det,
   output logic             locked,
   output logic             ambig,
   output logic             lost
`ifdef LED_DET_ERRCNT_EN
   ,
   output logic [ERR_W-1:0] err_cnt
`endif
);

   localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_TH = 4'(LOSS_CNT);

   state_t     state_q, state_nx;
   logic [7:0] prev_q;
   logic [3:0] cand_q, cand_nx;
   logic [3:0] cons_q, cons_nx;
   logic [3:0] miss_q, miss_nx;
   logic [1:0] mode_q, mode_nx;
   logic       locked_q, locked_nx;
   logic       ambig_q, ambig_nx;
   logic       lost_q, lost_nx;
   logic       err_inc;

   logic [3:0] m;
   logic       hit;
   logic [3:0] h_cand;
   logic [3:0] h_cons;
   logic [3:0] miss_inc;

   led_step_match u_match (
      .prev (prev_q),
      .cur  (led_in),
      .m    (m)
   );

   assign hit    = |(cand_q & m);
   assign h_cand = hit ? (cand_q & m) : m;
   assign h_cons = hit ? sat_inc4(cons_q) : {3'b0, |m};
   assign miss_inc = sat_inc4(miss_q);

   always_comb begin
      state_nx  = state_q;
      cand_nx   = cand_q;
      cons_nx   = cons_q;
      miss_nx   = miss_q;
      mode_nx   = mode_q;
      locked_nx = locked_q;
      ambig_nx  = 1'b0;
      lost_nx   = 1'b0;
      err_inc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_nx = HUNT;
         end
         HUNT: begin
            cand_nx = h_cand;
            cons_nx = h_cons;
            if (popcnt4(h_cand) == 3'd1 && h_cons >= LOCK_TH) begin
               state_nx  = LOCKED;
               locked_nx = 1'b1;
               mode_nx   = onehot_idx(h_cand);
            end else begin
               ambig_nx = popcnt4(h_cand) > 3'd1;
            end
         end
         LOCKED: begin
            if (m[mode_q]) begin
               miss_nx = 4'd0;
            end else begin
               err_inc = 1'b1;
               miss_nx = miss_inc;
               // Mode changes re-enter the hunt from this step's matches.
               if (miss_inc >= LOSS_TH) begin
                  state_nx  = HUNT;
                  locked_nx = 1'b0;
                  lost_nx   = 1'b1;
                  cand_nx   = m;
                  cons_nx   = {3'b0, |m};
                  miss_nx   = 4'd0;
                  ambig_nx  = popcnt4(m) > 3'd1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prev_q   <= 8'h00;
         cand_q   <= 4'b0000;
         cons_q   <= 4'd0;
         miss_q   <= 4'd0;
         mode_q   <= 2'd0;
         locked_q <= 1'b0;
         ambig_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else if (clr) begin
         state_q  <= IDLE;
         prev_q   <= 8'h00;
         cand_q   <= 4'b0000;
         cons_q   <= 4'd0;
         miss_q   <= 4'd0;
         mode_q   <= 2'd0;
         locked_q <= 1'b0;
         ambig_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_nx;
         prev_q   <= led_in;
         cand_q   <= cand_nx;
         cons_q   <= cons_nx;
         miss_q   <= miss_nx;
         mode_q   <= mode_nx;
         locked_q <= locked_nx;
         ambig_q  <= ambig_nx;
         lost_q   <= lost_nx;
      end
   end

   assign mode_det = mode_q;
   assign locked   = locked_q;
   assign ambig    = ambig_q;
   assign lost     = lost_q;

`ifdef LED_DET_ERRCNT_EN
   logic [ERR_W-1:0] err_q;

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if (clr) begin
         err_q <= '0;
      end else if (err_inc && !(&err_q)) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign err_cnt = err_q;
`else
   logic unused_err;
   assign unused_err = err_inc;
`endif

endmodule

// File: tb/tb_led_mode_detector.sv
// Directed-vector bench for led_mode_detector with default
// LOCK_CNT=3, LOSS_CNT=2.
module tb_led_mode_detector;

   logic       clk_1 = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] led_in = 8'h00;
   logic [1:0] mode_det;
   logic       locked;
   logic       ambig;
   logic       lost;
`ifdef LED_DET_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int n_chk = 0;
   int n_pass = 0;

   led_mode_detector dut (
      .clk_1    (clk_1),
      .rst_n    (rst_n),
      .clr      (clr),
      .led_in   (led_in),
      .mode_det (mode_det),
      .locked   (locked),
      .ambig    (ambig),
      .lost     (lost)
`ifdef LED_DET_ERRCNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   always #5 clk_1 = ~clk_1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input logic [7:0] v);
      led_in = v;
      @(posedge clk_1);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(8'h5A);
      clr = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] md,
                          input logic lk, input logic am,
                          input logic ls);
      chk({tag, ".mode"}, 32'(mode_det), 32'(md));
      chk({tag, ".locked"}, 32'(locked), 32'(lk));
      chk({tag, ".ambig"}, 32'(ambig), 32'(am));
      chk({tag, ".lost"}, 32'(lost), 32'(ls));
   endtask

   initial begin
      #12;
      chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_1);
      rst_n = 1'b1;
      @(posedge clk_1);
      #1;

      // rotate-left
      step(8'h01);
      step(8'h02);
      chk_out("rotl2", 2'd0, 1'b0, 1'b0, 1'b0);
      step(8'h04);
      chk_out("rotl3", 2'd0, 1'b0, 1'b0, 1'b0);
      step(8'h08);
      chk_out("rotl4", 2'd0, 1'b1, 1'b0, 1'b0);
      step(8'h10);
      chk_out("rotl5", 2'd0, 1'b1, 1'b0, 1'b0);

      // clr while locked, then IDLE must swallow the first sample
      do_clr();
      chk_out("clr", 2'd0, 1'b0, 1'b0, 1'b0);
      step(8'h02);
      step(8'h04);
      step(8'h08);
      chk("idle_cap.locked", 32'(locked), 32'd0);
      step(8'h10);
      chk_out("idle_lock", 2'd0, 1'b1, 1'b0, 1'b0);

      // blink
      do_clr();
      step(8'h01);
      step(8'hFE);
      step(8'h01);
      chk("blink3.locked", 32'(locked), 32'd0);
      step(8'hFE);
      chk_out("blink4", 2'd2, 1'b1, 1'b0, 1'b0);

      // rotate-right
      do_clr();
      step(8'h80);
      step(8'h40);
      step(8'h20);
      chk("rotr3.locked", 32'(locked), 32'd0);
      step(8'h10);
      chk_out("rotr4", 2'd1, 1'b1, 1'b0, 1'b0);

      // fixed after a fully ambiguous step
      do_clr();
      step(8'h55);
      step(8'hAA);
      chk_out("fix2", 2'd0, 1'b0, 1'b1, 1'b0);
      step(8'hAA);
      chk_out("fix3", 2'd0, 1'b0, 1'b0, 1'b0);
      step(8'hAA);
      chk_out("fix4", 2'd3, 1'b1, 1'b0, 1'b0);

      // steady zero never locks
      do_clr();
      for (int i = 0; i < 20; i++) begin
         step(8'h00);
         if (i > 0) chk("zero.locked", 32'(locked), 32'd0);
      end
      chk_out("zero20", 2'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(8'hFF);
      chk_out("ones20", 2'd0, 1'b0, 1'b1, 1'b0);

      // loss and relock
      do_clr();
      step(8'h01);
      step(8'h02);
      step(8'h04);
      step(8'h08);
      step(8'h10);
      chk_out("l_lock", 2'd0, 1'b1, 1'b0, 1'b0);
      step(8'h20);
      chk_out("l_hit", 2'd0, 1'b1, 1'b0, 1'b0);
      step(8'hAA);
      chk_out("l_miss1", 2'd0, 1'b1, 1'b0, 1'b0);
      step(8'hAA);
      chk_out("l_miss2", 2'd0, 1'b0, 1'b0, 1'b1);
`ifdef LED_DET_ERRCNT_EN
      chk("l_err", 32'(err_cnt), 32'd2);
`endif
      step(8'hAA);
      chk_out("l_re1", 2'd0, 1'b0, 1'b0, 1'b0);
      step(8'hAA);
      chk_out("l_re2", 2'd3, 1'b1, 1'b0, 1'b0);

      // async reset mid-cycle while locked
      @(negedge clk_1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("arst", 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef LED_DET_ERRCNT_EN
      chk("arst_err", 32'(err_cnt), 32'd0);
`endif
      @(negedge clk_1);
      rst_n = 1'b1;
      step(8'h80);
      step(8'h40);
      step(8'h20);
      step(8'h10);
      chk_out("post_rst", 2'd1, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_mode_detector.md
Name: led_mode_detector

Overview:
- Observes the 8-bit LED pattern bus driven by the LED pattern generator, one sample per generator step.
- Infers which generator mode is running: rotate-left (0), rotate-right (1), invert-blink (2) or fixed 8'hAA (3).
- Reports the detected mode with lock/ambiguity/loss status, for self-check and for closed-loop display on the board.

Parameters:
- LOCK_CNT, 3, consecutive consistent steps required before lock (1..15).
- LOSS_CNT, 2, consecutive mismatching steps while locked before lock is dropped (1..15).
- ERR_W, 8, width of the error counter (optional feature only).

Ports:
- clk_1  input  1  step clock, same clock that advances the generator; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; same effect as reset, and takes priority over sampling.
- led_in  input  8  logical LED pattern (bit=1 means lit), sampled every posedge clk_1.
- mode_det  output  2  detected mode; valid only while locked=1.
- locked  output  1  a single mode has been confirmed.
- ambig  output  1  current candidate set holds more than one mode.
- lost  output  1  one-cycle pulse when lock is dropped.
- err_cnt  output  ERR_W  saturating mismatch count; present only with the optional feature.

Behaviour:
- Reset or clr: all outputs 0; prev=0; cand=4'b0000; cons_cnt=0; miss_cnt=0; state=IDLE.
- Registers: prev holds the previous sample; every posedge loads prev<=led_in.
- Match vector m[3:0], combinational on (prev, cur=led_in):
  - m0 = (cur == {prev[6:0],prev[7]}).
  - m1 = (cur == {prev[0],prev[7:1]}).
  - m2 = (cur == ~prev).
  - m3 = (cur == 8'hAA).
- IDLE: capture first sample only -> HUNT. No match evaluation.
- HUNT:
  - If (cand & m) != 0 and cand != 0: cand<=cand&m; cons_cnt<=sat(cons_cnt+1).
  - Else: cand<=m; cons_cnt<=(m!=0)?1:0.
  - When the next cand is one-hot and the next cons_cnt >= LOCK_CNT: -> LOCKED. mode_det gets the index of the set bit and locked<=1 on the same edge.
  - First lock therefore appears after LOCK_CNT+1 samples.
- LOCKED:
  - m[mode_det]=1: stay; miss_cnt<=0.
  - Otherwise miss_cnt<=miss_cnt+1, with no other change.
  - When the next miss_cnt reaches LOSS_CNT: -> HUNT; locked<=0; lost<=1 for one cycle; cand<=m; cons_cnt<=(m!=0); miss_cnt<=0.
  - mode_det holds its last value after loss.
- ambig = registered (popcount(cand) > 1), updated in HUNT only; forced 0 in IDLE and LOCKED.
- Ambiguous steps never lock. Examples:
  - 8'h00->8'h00 gives m={0,1}.
  - 8'hFF->8'hFF gives m={0,1}.
  - 8'h55->8'hAA gives m={0,1,2,3}.
  - The block stays in HUNT until a distinguishing step arrives.
- A mode change while locked is handled by the loss path followed by re-hunt. There is no direct mode switch.
- cons_cnt and miss_cnt are 4 bits, saturating.

Optional Feature:
- Macro LED_DET_ERRCNT_EN.
- Defined: err_cnt port exists. It increments by 1 on every LOCKED-state mismatch step, saturates at all-ones, and is cleared only by reset/clr.
- Undefined: no err_cnt port and no counter logic; all other behaviour identical.

Decomposition:
- Package led_det_pkg:
  - state enum {IDLE,HUNT,LOCKED}.
  - mode constants MODE_ROTL=2'd0, MODE_ROTR=2'd1, MODE_BLINK=2'd2, MODE_FIXED=2'd3.
  - FIXED_PATTERN=8'hAA.
- Sub-module led_step_match: purely combinational (prev, cur) -> m[3:0]. This keeps the match rules unit-testable.

Test Plan:
- Rotate-left: led_in 01,02,04,08,10, LOCK_CNT=3 -> locked=1, mode_det=0 after the 4th sample; ambig=0 throughout.
- Blink: 01,FE,01,FE -> locked=1, mode_det=2 after the 4th sample. Rotate-right check: 80,40,20,10 -> mode_det=1.
- Fixed/ambiguous:
  - 55,AA,AA,AA,AA -> ambig=1 after the 2nd sample, then locked=1, mode_det=3.
  - Steady 00,00,... for 20 samples -> locked stays 0, ambig=1.
- Loss and relock:
  - Locked on mode 0 at 10, then 20,AA,AA -> lost pulse on the 2nd mismatch and locked=0.
  - Continued AA samples -> relock to mode 3.
- Reset/clr mid-operation: assert clr while locked -> next edge all outputs 0, state IDLE; async rst_n low mid-cycle -> outputs 0 immediately.
- With LED_DET_ERRCNT_EN, ERR_W=2: locked mode 0, LOSS_CNT=15, feed 5 mismatches -> err_cnt saturates at 3.
